// File: rtl/dtc_tree_engine_if.sv
// rtl/dtc_tree_engine_if.sv - feature/result handshake and node-table config bundle for dtc_tree_engine (out_depth present under DTC_DEPTH_OUT_EN)
interface dtc_tree_engine_if #(
    parameter int N_FEATURES  = 12,
    parameter int CLASS_W     = 3,
    parameter int NODE_ADDR_W = 8,
    parameter int FEAT_IDX_W  = 4,
    parameter int MAX_DEPTH   = 12
);
    localparam int ENTRY_W = 1 + FEAT_IDX_W + 2 * NODE_ADDR_W + CLASS_W;

    logic                   in_valid;
    logic                   in_ready;
    logic [N_FEATURES-1:0]  in_feat;
    logic                   out_valid;
    logic                   out_ready;
    logic [CLASS_W-1:0]     out_class;
    logic                   out_err;
    logic                   cfg_we;
    logic                   cfg_ready;
    logic [NODE_ADDR_W-1:0] cfg_addr;
    logic [ENTRY_W-1:0]     cfg_data;
`ifdef DTC_DEPTH_OUT_EN
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    logic [DEPTH_W-1:0]     out_depth;

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_class, out_err, cfg_ready, out_depth
    );
    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_class, out_err, cfg_ready, out_depth
    );
`else
    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_class, out_err, cfg_ready
    );
    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_class, out_err, cfg_ready
    );
`endif
endinterface

// File: rtl/dtc_tree_engine.sv
// rtl/dtc_tree_engine.sv - programmable sequential decision-tree classifier, one node per clock (optional out_depth via DTC_DEPTH_OUT_EN)
module dtc_tree_engine #(
    parameter int N_FEATURES    = 12,
    parameter int CLASS_W       = 3,
    parameter int NODE_COUNT    = 256,
    parameter int NODE_ADDR_W   = 8,
    parameter int FEAT_IDX_W    = 4,
    parameter int MAX_DEPTH     = 12,
    parameter int DEFAULT_CLASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    dtc_tree_engine_if.slave  bus
);
    localparam int ENTRY_W = 1 + FEAT_IDX_W + 2 * NODE_ADDR_W + CLASS_W;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [ENTRY_W-1:0] LEAF_RESET = {1'b1, {(ENTRY_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [ENTRY_W-1:0]     node_tab [NODE_COUNT];
    logic [N_FEATURES-1:0]  feat_q;
    logic [NODE_ADDR_W-1:0] ptr;
    logic [DEPTH_W-1:0]     depth;
    logic [CLASS_W-1:0]     class_q;
    logic                   err_q;

    logic                   in_ready_c;
    logic                   cfg_ready_c;
    logic                   out_valid_c;
    logic                   in_accept;
    logic                   cfg_commit;
    logic                   walk_done;
    logic                   walk_err;
    logic                   walk_step;
    logic [CLASS_W-1:0]     walk_class;

    logic                   ptr_ok;
    logic                   cfg_addr_ok;
    logic [ENTRY_W-1:0]     node;
    logic                   node_leaf;
    logic [FEAT_IDX_W-1:0]  node_feat;
    logic [NODE_ADDR_W-1:0] node_one;
    logic [NODE_ADDR_W-1:0] node_zero;
    logic [CLASS_W-1:0]     node_class;
    logic                   feat_ok;
    logic                   feat_bit;

    assign ptr_ok      = ({1'b0, ptr} < (NODE_ADDR_W+1)'(NODE_COUNT));
    assign cfg_addr_ok = ({1'b0, bus.cfg_addr} < (NODE_ADDR_W+1)'(NODE_COUNT));

    // Out-of-range pointers read a harmless leaf image; the WALK decode flags them as errors first.
    assign node       = ptr_ok ? node_tab[ptr] : LEAF_RESET;
    assign node_leaf  = node[ENTRY_W-1];
    assign node_feat  = node[ENTRY_W-2 -: FEAT_IDX_W];
    assign node_one   = node[CLASS_W + NODE_ADDR_W +: NODE_ADDR_W];
    assign node_zero  = node[CLASS_W +: NODE_ADDR_W];
    assign node_class = node[CLASS_W-1:0];

    assign feat_ok  = ({1'b0, node_feat} < (FEAT_IDX_W+1)'(N_FEATURES));
    assign feat_bit = feat_ok ? feat_q[node_feat] : 1'b0;

    assign in_accept  = in_ready_c && bus.in_valid;
    assign cfg_commit = cfg_ready_c && bus.cfg_we && cfg_addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        cfg_ready_c = 1'b0;
        out_valid_c = 1'b0;
        walk_done   = 1'b0;
        walk_err    = 1'b0;
        walk_step   = 1'b0;
        walk_class  = '0;
        case (state)
            IDLE: begin
                in_ready_c  = 1'b1;
                cfg_ready_c = 1'b1;
                if (bus.in_valid) begin
                    next_state = WALK;
                end
            end
            WALK: begin
                if (!ptr_ok) begin
                    walk_done  = 1'b1;
                    walk_err   = 1'b1;
                    walk_class = CLASS_W'(DEFAULT_CLASS);
                end else if (node_leaf) begin
                    walk_done  = 1'b1;
                    walk_class = node_class;
                end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
                    walk_done  = 1'b1;
                    walk_err   = 1'b1;
                    walk_class = CLASS_W'(DEFAULT_CLASS);
                end else begin
                    walk_step = 1'b1;
                end
                if (walk_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A write and an accept in the same IDLE cycle are safe: WALK reads the table one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                node_tab[i] <= LEAF_RESET;
            end
        end else if (cfg_commit) begin
            node_tab[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q  <= '0;
            ptr     <= '0;
            depth   <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (in_accept) begin
                feat_q <= bus.in_feat;
                ptr    <= '0;
                depth  <= '0;
            end else if (walk_step) begin
                ptr   <= feat_bit ? node_one : node_zero;
                depth <= depth + DEPTH_W'(1);
            end
            if (walk_done) begin
                class_q <= walk_class;
                err_q   <= walk_err;
            end
        end
    end

`ifdef DTC_DEPTH_OUT_EN
    logic [DEPTH_W-1:0] depth_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (walk_done) begin
            depth_q <= depth;
        end
    end

    assign bus.out_depth = depth_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.cfg_ready = cfg_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_class = class_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_dtc_tree_engine.sv
// tb/tb_dtc_tree_engine.sv - scoreboard bench for dtc_tree_engine
module tb_dtc_tree_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] cls;
        logic       err;
        int         lat;
        int         dep;
    } exp_t;

    exp_t sb[$];

    dtc_tree_engine_if bus_if ();

    dtc_tree_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic leaf, input logic [3:0] fi,
                             input logic [7:0] one, input logic [7:0] zero, input logic [2:0] cls);
        bus_if.cfg_we   = 1'b1;
        bus_if.cfg_addr = addr;
        bus_if.cfg_data = {leaf, fi, one, zero, cls};
        check("cfg_ready_idle", bus_if.cfg_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.cfg_we = 1'b0;
    endtask

    task automatic run(input logic [11:0] feat, input logic [2:0] cls, input logic err,
                       input int lat, input int dep, input int hold);
        exp_t e;
        exp_t got;
        int   k;
        check("in_ready_idle", bus_if.in_ready, 1);
        bus_if.in_valid = 1'b1;
        bus_if.in_feat  = feat;
        e.cls = cls;
        e.err = err;
        e.lat = lat;
        e.dep = dep;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        k = 0;
        while (!bus_if.out_valid && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (!bus_if.out_valid) begin
            check("timeout_out_valid", 0, 1);
            void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
            return;
        end
        got = sb.pop_front();
        check("out_class", bus_if.out_class, got.cls);
        check("out_err", bus_if.out_err, got.err);
        check("latency", k + 1, got.lat);
`ifdef DTC_DEPTH_OUT_EN
        check("out_depth", bus_if.out_depth, got.dep);
`endif
        for (int h = 0; h < hold; h++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_feat  = 12'h000;
            bus_if.cfg_we   = 1'b1;
            bus_if.cfg_addr = 8'd1;
            bus_if.cfg_data = {1'b1, 4'd0, 8'd0, 8'd0, 3'd7};
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", bus_if.out_valid, 1);
            check("hold_class", bus_if.out_class, got.cls);
            check("hold_in_ready", bus_if.in_ready, 0);
            check("hold_cfg_ready", bus_if.cfg_ready, 0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.cfg_we    = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check("valid_dropped", bus_if.out_valid, 0);
    endtask

    initial begin
        int seen;
        bus_if.in_valid  = 1'b0;
        bus_if.in_feat   = '0;
        bus_if.out_ready = 1'b0;
        bus_if.cfg_we    = 1'b0;
        bus_if.cfg_addr  = '0;
        bus_if.cfg_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", bus_if.in_ready, 1);
        check("rst_cfg_ready", bus_if.cfg_ready, 1);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_out_class", bus_if.out_class, 0);
        check("rst_out_err", bus_if.out_err, 0);
`ifdef DTC_DEPTH_OUT_EN
        check("rst_out_depth", bus_if.out_depth, 0);
`endif

        run(12'h000, 3'd0, 1'b0, 2, 0, 0);

        cfg_write(8'd0, 1'b0, 4'd3, 8'd1, 8'd2, 3'd0);
        cfg_write(8'd1, 1'b1, 4'd0, 8'd0, 8'd0, 3'b010);
        cfg_write(8'd2, 1'b1, 4'd0, 8'd0, 8'd0, 3'b001);
        run(12'h008, 3'b010, 1'b0, 3, 1, 0);
        run(12'h000, 3'b001, 1'b0, 3, 1, 0);
        run(12'hFF7, 3'b001, 1'b0, 3, 1, 0);

        // Feature index beyond the vector reads as 0, so the zero child wins.
        cfg_write(8'd0, 1'b0, 4'd13, 8'd1, 8'd2, 3'd0);
        run(12'hFFF, 3'b001, 1'b0, 3, 1, 0);

        cfg_write(8'd0, 1'b0, 4'd0, 8'd0, 8'd0, 3'd0);
        run(12'h001, 3'd0, 1'b1, 14, 12, 0);

        cfg_write(8'd0, 1'b0, 4'd3, 8'd1, 8'd2, 3'd0);
        run(12'h008, 3'b010, 1'b0, 3, 1, 5);
        run(12'h008, 3'b010, 1'b0, 3, 1, 0);

        for (int i = 0; i < 5; i++) begin
            cfg_write(8'(i), 1'b0, 4'd0, 8'(i + 1), 8'(i + 1), 3'd0);
        end
        cfg_write(8'd5, 1'b1, 4'd0, 8'd0, 8'd0, 3'd5);
        run(12'h000, 3'd5, 1'b0, 7, 5, 0);

        bus_if.in_valid = 1'b1;
        bus_if.in_feat  = 12'h000;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("in_ready_after_rst", bus_if.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.out_valid) seen++;
        end
        check("no_result_after_rst", seen, 0);
        run(12'h000, 3'd0, 1'b0, 2, 0, 0);

        check("sb_empty_at_end", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
